// File: rtl/s420_ctrl_loader.sv
`default_nettype none
// s420_ctrl_loader: prescaled count enable P_0 and a serially loaded compare-select
// vector c_out for the s420_1 block; new vectors commit atomically on a P_0 tick.
module s420_ctrl_loader #(
  parameter int              CW      = 17,
  parameter int              PW      = 8,
  parameter logic [CW-1:0]   C_RESET = '0
) (
  input  logic          blif_clk_net,
  input  logic          blif_reset_net,
  input  logic          run,
  input  logic [PW-1:0] div,
  input  logic          sdi,
  input  logic          sdi_valid,
  input  logic          sdi_last,
  output logic          cfg_ready,
  output logic          frame_err,
  output logic          P_0,
  output logic [CW-1:0] c_out
);

  localparam logic [4:0] CW5 = 5'(CW);
  localparam logic [5:0] CW6 = 6'(CW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] shreg, shreg_nxt, c_nxt, shreg_shift;
  logic [4:0]    bcnt, bcnt_nxt;
  logic [5:0]    bcnt_inc;
  logic          err_nxt, tick, accept;

  assign tick        = run && (pcnt >= div);
  assign cfg_ready   = (state != COMMIT);
  assign accept      = sdi_valid && cfg_ready;
  assign bcnt_inc    = {1'b0, bcnt} + 6'd1;
  assign shreg_shift = {shreg[CW-2:0], sdi};

  // The >= compare lets a shrinking div fire immediately instead of wrapping pcnt.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      pcnt <= '0;
      P_0  <= 1'b0;
    end else if (!run) begin
      pcnt <= '0;
      P_0  <= 1'b0;
    end else if (tick) begin
      pcnt <= '0;
      P_0  <= 1'b1;
    end else begin
      pcnt <= pcnt + PW'(1);
      P_0  <= 1'b0;
    end
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      frame_err <= 1'b0;
      c_out     <= C_RESET;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bcnt      <= bcnt_nxt;
      frame_err <= err_nxt;
      c_out     <= c_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    c_nxt     = c_out;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt = shreg_shift;
          bcnt_nxt  = 5'd1;
          if (sdi_last) err_nxt = 1'b1;
          else          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_nxt = shreg_shift;
          bcnt_nxt  = (bcnt_inc >= CW6) ? CW5 : bcnt_inc[4:0];
          if (sdi_last) begin
            // An over-length frame ending right at bit CW+1 is malformed too.
            if (bcnt_inc == CW6) begin
              state_nxt = COMMIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else if (bcnt == CW5) begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && sdi_last) state_nxt = IDLE;
      end
      COMMIT: begin
        if (!run || tick) begin
          c_nxt     = shreg;
          bcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_s420_ctrl_loader.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized scoreboard bench for s420_ctrl_loader: the driver queues expected
// frame errors and committed vectors, a negedge monitor compares against them.
module tb_s420_ctrl_loader;
  localparam int CW = 17;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [PW-1:0] div = '0;
  logic          sdi = 1'b0;
  logic          sdi_valid = 1'b0;
  logic          sdi_last = 1'b0;
  logic          cfg_ready, frame_err, P_0;
  logic [CW-1:0] c_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  s420_ctrl_loader #(.CW(CW), .PW(PW), .C_RESET('0)) dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst_n),
    .run           (run),
    .div           (div),
    .sdi           (sdi),
    .sdi_valid     (sdi_valid),
    .sdi_last      (sdi_last),
    .cfg_ready     (cfg_ready),
    .frame_err     (frame_err),
    .P_0           (P_0),
    .c_out         (c_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference prescaler: cycles elapsed since the last enable pulse or run start.
  int   since = 0;
  logic exp_p0 = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n || !run) begin
      since  = 0;
      exp_p0 = 1'b0;
    end else if (since >= int'(div)) begin
      since  = 0;
      exp_p0 = 1'b1;
    end else begin
      since  = since + 1;
      exp_p0 = 1'b0;
    end
  end

  logic [CW-1:0] commit_q[$];
  int            err_q[$];

  // Monitor
  logic [CW-1:0] cur_exp = '0;
  logic          prev_ready = 1'b1;
  int            low_cycles = 0;
  logic          saw_run_hi = 1'b0, saw_run_lo = 1'b0;
  always @(negedge clk) begin
    logic exp_err;
    if (!rst_n) begin
      check("rst_P_0", 32'(P_0), 32'd0);
      check("rst_c_out", 32'(c_out), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      commit_q.delete();
      err_q.delete();
      cur_exp    = '0;
      prev_ready = 1'b1;
      low_cycles = 0;
    end else begin
      check("P_0", 32'(P_0), 32'(exp_p0));
      exp_err = (err_q.size() > 0) && (err_q[0] + 1 == cyc);
      check("frame_err", 32'(frame_err), 32'(exp_err));
      if (exp_err) void'(err_q.pop_front());
      if (!prev_ready && cfg_ready) begin
        check("commit_pending", 32'(commit_q.size() > 0), 32'd1);
        if (commit_q.size() > 0) cur_exp = commit_q.pop_front();
        if (!saw_run_hi) check("commit_latency_run0", 32'(low_cycles), 32'd1);
        if (!saw_run_lo) check("commit_on_P_0", 32'(P_0), 32'd1);
      end
      check("c_out", 32'(c_out), 32'(cur_exp));
      if (!cfg_ready) begin
        if (prev_ready) begin
          low_cycles = 0;
          saw_run_hi = 1'b0;
          saw_run_lo = 1'b0;
        end
        low_cycles = low_cycles + 1;
        saw_run_hi = saw_run_hi | run;
        saw_run_lo = saw_run_lo | !run;
      end
      prev_ready = cfg_ready;
    end
  end

  task automatic tick_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic last, input bit push_err,
                          input bit push_commit, input logic [CW-1:0] val);
    int guard = 0;
    bit done  = 0;
    tick_cycles($urandom_range(0, 2));
    sdi       = b;
    sdi_last  = last;
    sdi_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (cfg_ready) begin
        done = 1;
        if (push_err)    err_q.push_back(cyc);
        if (push_commit) commit_q.push_back(val);
      end else if (++guard > 300) begin
        checks++;
        errors++;
        $display("FAIL cfg_ready_timeout: got 0 expected 1 within 300 cycles (cycle %0d)", cyc);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    sdi_valid = 1'b0;
    sdi_last  = 1'b0;
  endtask

  // n bits, MSB first, taken from data[n-1:0]; last flag on bit n.
  task automatic send_frame(input int n, input logic [31:0] data);
    for (int i = 1; i <= n; i++)
      send_bit(data[n-i], i == n,
               (n < CW && i == n) || (n > CW && i == CW + 1),
               (n == CW && i == n), data[CW-1:0]);
  endtask

  task automatic send_partial(input int n);
    for (int i = 1; i <= n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    tick_cycles(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int kind, n;
    tick_cycles(3);
    rst_n = 1'b1;

    run = 1'b1; div = 8'd3;
    tick_cycles(20);
    div = 8'd0;
    tick_cycles(8);
    run = 1'b0;
    tick_cycles(2);
    div = 8'd7; run = 1'b1;
    tick_cycles(5);
    div = 8'd2;
    tick_cycles(12);

    run = 1'b0;
    tick_cycles(2);
    send_frame(CW, 32'h10001);
    tick_cycles(4);

    run = 1'b1; div = 8'd9;
    tick_cycles(3);
    send_frame(CW, 32'h0ABCD);
    tick_cycles(15);

    send_frame(5, 32'h15);
    send_frame(CW, 32'h1F0F0);
    tick_cycles(12);
    send_frame(20, 32'hFFFFF);
    send_frame(CW, 32'h00F31);
    tick_cycles(12);

    for (int f = 0; f < 60; f++) begin
      run  = 1'($urandom_range(0, 1));
      div  = PW'($urandom_range(0, 12));
      kind = $urandom_range(0, 9);
      n    = (kind < 6) ? CW : (kind < 8) ? $urandom_range(1, CW - 1) : $urandom_range(CW + 1, CW + 5);
      send_frame(n, $urandom);
    end
    tick_cycles(20);

    run = 1'b0;
    send_partial(8);
    apply_reset(2);
    send_frame(CW, 32'h13579);
    tick_cycles(4);

    run = 1'b1; div = 8'd20;
    tick_cycles(2);
    send_frame(CW, 32'h1AAAA);
    apply_reset(2);
    run = 1'b0;
    send_frame(CW, 32'h05555);
    tick_cycles(10);

    check("commit_q_drained", 32'(commit_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/s420_ctrl_loader.md
# s420_ctrl_loader

Upstream control stage for the s420_1 counter/compare block. It produces that block's count-enable `P_0` from a programmable prescaler. It also supplies the 17-bit compare-select vector `C_0..C_16`, loaded through a serial valid/ready port into a shadow register. New vectors are committed atomically, aligned to a `P_0` pulse, so the downstream `Z` never sees a partially loaded mask.

## Interface
- `CW`, 17: compare-vector width; `c_out[i]` drives `C_i`.
- `PW`, 8: prescaler divisor width.
- `C_RESET`, 17'h00000: value of `c_out` in reset.
- `blif_clk_net`  in  1  clock; all state on rising edge.
- `blif_reset_net`  in  1  reset, asynchronous, active-low (0 = reset).
- `run`  in  1  enable prescaler.
- `div`  in  PW  divisor; `P_0` period = `div`+1 cycles.
- `sdi`  in  1  serial config bit.
- `sdi_valid`  in  1  `sdi` qualifier.
- `sdi_last`  in  1  marks final bit of a frame; valid only with `sdi_valid`.
- `cfg_ready`  out  1  bit accepted on a cycle where `sdi_valid`&`cfg_ready`.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.
- `P_0`  out  1  count enable to the s420_1 block.
- `c_out`  out  CW  compare-select vector to the s420_1 block.

## Operation
- **Prescaler:** `pcnt`[PW-1:0].
  - `run`=0: `pcnt`<=0, `P_0`<=0.
  - `run`=1, define `tick` = (`pcnt` >= `div`).
    - `tick`: `pcnt`<=0, `P_0`<=1.
    - Otherwise: `pcnt`<=`pcnt`+1, `P_0`<=0.
  - The >= compare makes a `div` decrease below `pcnt` produce a tick on the next edge, with no wrap.
  - `div`=0 holds `P_0`=1 continuously while `run`=1.
- **Loader FSM:** states IDLE, SHIFT, DRAIN, COMMIT. Registers: `shreg`[CW-1:0] and `bcnt` (5 bits, saturating at CW). Accept = `sdi_valid`&`cfg_ready`.
  - **IDLE:** on accept, `shreg`<={`shreg`[CW-2:0],`sdi`} (MSB first, first bit ends in `c_out`[16]) and `bcnt`<=1.
    - If `sdi_last` on that bit: frame_err, back to IDLE.
    - Otherwise go to SHIFT.
  - **SHIFT:** on accept, shift and increment `bcnt`.
    - `sdi_last` with new count == CW → COMMIT.
    - `sdi_last` with new count < CW → `frame_err`, IDLE.
    - Accept with `bcnt`==CW and no `sdi_last` → `frame_err`, DRAIN.
  - **DRAIN:** accept and discard bits until an accepted bit carries `sdi_last`, then IDLE. No second `frame_err`.
  - **COMMIT:** `cfg_ready`=0. Exit when `run`=0 or `tick`=1: `c_out`<=`shreg`, `bcnt`<=0, IDLE.
- **`cfg_ready`:** combinational, = (state != COMMIT). It is 1 during reset.
- **`sdi_valid` low:** holds all loader state; bits may be gapped arbitrarily.
- **Reset (async, any time):** state=IDLE, `shreg`=0, `bcnt`=0, `pcnt`=0, `P_0`=0, `frame_err`=0, `c_out`=`C_RESET`. A frame in progress is lost and a pending commit is dropped.

## Timing
- `P_0` is registered. With `run` high continuously from edge e0 (`pcnt`=0), `P_0` is high in the cycles after edges e`div`, e2`div`+1, …, i.e. every `div`+1 cycles.
- `run` falling: `P_0` is 0 after the next edge.
- Commit latency:
  - `run`=0: `c_out` updates on the edge after the last bit is accepted, plus 1 edge (COMMIT entry, then exit).
  - `run`=1: `c_out` updates on the same edge that raises `P_0`, while in COMMIT.
  - If `tick` is true on the edge that enters COMMIT, the commit waits for the following tick.
- `frame_err` is high exactly one cycle, after the edge that accepts the offending bit.
- Minimum frame-to-frame spacing: CW accepts plus 1 COMMIT cycle plus the tick wait.

## Test plan
- **Reset/idle:** assert `blif_reset_net`=0 mid-frame and mid-COMMIT → `P_0`=0, `c_out`=0, `cfg_ready`=1, `frame_err`=0. After release, a fresh frame loads correctly.
- **Prescaler:** `run`=1, `div`=3 → `P_0` pulses 1 cycle in 4. `div`=0 → `P_0` stays high. Drop `div` 7→2 while `pcnt`=5 → tick on the next edge, then period 3.
- **Load, run=0:** 17-bit frame 1_0000_0000_0000_0001 (17'h10001) with random `sdi_valid` gaps → `c_out`=17'h10001 two edges after the last bit. `cfg_ready` low exactly 1 cycle.
- **Load, run=1, `div`=9:** frame completes mid-period → `c_out` stays at its old value until the edge raising `P_0`, changes on that edge, and `cfg_ready` is low until then.
- **Short frame:** `sdi_last` on bit 5 → `frame_err` single pulse, `c_out` unchanged, the next good frame loads.
- **Long frame:** 20 bits with `sdi_last` on bit 20 → one `frame_err` after bit 18, bits 19–20 drained, `c_out` unchanged, back to IDLE.
